flit_packetizer: RTL and testbench

//  Transmit side of the NoC flit format: turns a packet request (dest, length) plus a stream of

---
 rtl/flit_packetizer_if.sv | 37 +++
 rtl/flit_packetizer.sv | 125 ++++++++++++
 tb/tb_flit_packetizer.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/flit_packetizer_if.sv
// Handshake bundle between the core-side packetizer and its user / the router local port.
// Pure wiring, no latency.
// Backpressure is carried by pkt_ready, data_ready and flit_ready.
interface flit_packetizer_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int PhitPerFlit = 2,
  parameter int TYPE_WIDTH  = 2,
  parameter int DEST_WIDTH  = 4,
  parameter int MAX_LEN     = 8
);
  localparam int FW    = DATA_WIDTH * PhitPerFlit;
  localparam int LEN_W = $clog2(MAX_LEN + 1);

  logic                     pkt_valid;
  logic                     pkt_ready;
  logic [DEST_WIDTH-1:0]    pkt_dest;
  logic [LEN_W-1:0]         pkt_len;
  logic                     data_valid;
  logic                     data_ready;
  logic [FW-TYPE_WIDTH-1:0] data_in;
  logic [FW-1:0]            flit_out;
  logic                     flit_valid;
  logic                     flit_ready;
  logic                     busy;

  // Master: the core driving requests/data and the router sinking flits.
  modport master (
    output pkt_valid, pkt_dest, pkt_len, data_valid, data_in, flit_ready,
    input  pkt_ready, data_ready, flit_out, flit_valid, busy
  );

  // Slave: the packetizer itself.
  modport slave (
    input  pkt_valid, pkt_dest, pkt_len, data_valid, data_in, flit_ready,
    output pkt_ready, data_ready, flit_out, flit_valid, busy
  );
endinterface

// File: rtl/flit_packetizer.sv
// Turns a (dest, len) request plus data words into HEAD / PAYLOAD / TAIL flits.
// Latency: a flit is visible the cycle after its request/data handshake.
// Backpressure: single output slot; inputs are accepted only when the slot is free.
module flit_packetizer #(
  parameter int DATA_WIDTH  = 32,
  parameter int PhitPerFlit = 2,
  parameter int TYPE_WIDTH  = 2,
  parameter int DEST_WIDTH  = 4,
  parameter int MAX_LEN     = 8
) (
  input logic               clk,
  input logic               rst,
  flit_packetizer_if.slave  bus
);
  localparam int FW    = DATA_WIDTH * PhitPerFlit;
  localparam int LEN_W = $clog2(MAX_LEN + 1);
  localparam int DW    = FW - TYPE_WIDTH;

  localparam logic [TYPE_WIDTH-1:0] T_HEAD = TYPE_WIDTH'(1);
  localparam logic [TYPE_WIDTH-1:0] T_PAY  = TYPE_WIDTH'(2);
  localparam logic [TYPE_WIDTH-1:0] T_TAIL = TYPE_WIDTH'(3);
  localparam logic [LEN_W-1:0]      LEN_MAX = LEN_W'(MAX_LEN);

  typedef enum logic [1:0] {ST_IDLE, ST_BODY, ST_TAIL} state_t;

  state_t            state_q, state_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [FW-1:0]     flit_q, flit_d;
  logic              flit_vld_q, flit_vld_d;

  logic              slot_free;
  logic              pkt_rdy;
  logic              dat_rdy;
  logic              load;
  logic [LEN_W-1:0]  cnt_m1;

  assign slot_free = !flit_vld_q || bus.flit_ready;
  assign cnt_m1    = cnt_q - LEN_W'(1);

  // Next-state, output-slot load and ready generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    flit_d     = flit_q;
    flit_vld_d = flit_vld_q;
    pkt_rdy    = 1'b0;
    dat_rdy    = 1'b0;
    load       = 1'b0;

    if (!rst) begin
      unique case (state_q)
        ST_IDLE: begin
          pkt_rdy = slot_free;
          if (bus.pkt_valid && slot_free) begin
            load                           = 1'b1;
            flit_d                         = '0;
            flit_d[FW-1 -: TYPE_WIDTH]     = T_HEAD;
            flit_d[DEST_WIDTH-1:0]         = bus.pkt_dest;
            flit_d[DEST_WIDTH +: LEN_W]    = bus.pkt_len;
            cnt_d                          = bus.pkt_len;
            state_d = (bus.pkt_len >= LEN_W'(2)) ? ST_BODY : ST_TAIL;
          end
        end
        ST_BODY: begin
          dat_rdy = slot_free;
          if (bus.data_valid && slot_free) begin
            load   = 1'b1;
            flit_d = {T_PAY, bus.data_in};
            cnt_d  = cnt_m1;
            if (cnt_m1 == LEN_W'(1)) state_d = ST_TAIL;
          end
        end
        ST_TAIL: begin
          // cnt is 1 here for any non-empty packet, 0 only for a len=0 request.
          if (cnt_q == '0) begin
            if (slot_free) begin
              load    = 1'b1;
              flit_d  = {T_TAIL, {DW{1'b0}}};
              state_d = ST_IDLE;
            end
          end else begin
            dat_rdy = slot_free;
            if (bus.data_valid && slot_free) begin
              load    = 1'b1;
              flit_d  = {T_TAIL, bus.data_in};
              cnt_d   = cnt_m1;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // A new load keeps the slot full; otherwise a downstream accept empties it.
    if (load)                 flit_vld_d = 1'b1;
    else if (bus.flit_ready)  flit_vld_d = 1'b0;
  end

  // State, counter and output register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      flit_q     <= '0;
      flit_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      flit_q     <= flit_d;
      flit_vld_q <= flit_vld_d;
    end
  end

  assign bus.pkt_ready  = pkt_rdy;
  assign bus.data_ready = dat_rdy;
  assign bus.flit_out   = flit_q;
  assign bus.flit_valid = flit_vld_q;
  assign bus.busy       = (state_q != ST_IDLE);

  // Requests longer than MAX_LEN are outside the supported range.
  a_len_range: assert property (@(posedge clk) disable iff (rst)
    (bus.pkt_valid && bus.pkt_ready) |-> (bus.pkt_len <= LEN_MAX));

endmodule

// File: tb/tb_flit_packetizer.sv
// Directed bench for flit_packetizer: per-cycle vector table plus reset and gap sequences.
// Inputs driven 1 ns after the rising edge, outputs sampled 1 ns later.
// Flit handshakes are recorded at the same sample point for ordering checks.
module tb_flit_packetizer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  flit_packetizer_if bus ();
  flit_packetizer dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic        pv;
    logic [3:0]  dest;
    logic [3:0]  len;
    logic        dv;
    logic [61:0] dat;
    logic        fr;
    logic        e_v;
    logic [63:0] e_out;
    logic        e_busy;
    logic        e_pr;
    logic        e_dr;
  } vec_t;

  vec_t        vt[$];
  logic [63:0] cap[$];
  int          n_chk  = 0;
  int          n_fail = 0;

  function automatic logic [63:0] hd(input logic [3:0] d, input logic [3:0] l);
    return {2'd1, 54'd0, l, d};
  endfunction
  function automatic logic [63:0] pl(input logic [61:0] x);
    return {2'd2, x};
  endfunction
  function automatic logic [63:0] tl(input logic [61:0] x);
    return {2'd3, x};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic pv, input logic [3:0] d, input logic [3:0] l,
                     input logic dv, input logic [61:0] dat, input logic fr,
                     input logic ev, input logic [63:0] eo, input logic eb,
                     input logic epr, input logic edr);
    vec_t e;
    e.pv = pv; e.dest = d; e.len = l; e.dv = dv; e.dat = dat; e.fr = fr;
    e.e_v = ev; e.e_out = eo; e.e_busy = eb; e.e_pr = epr; e.e_dr = edr;
    vt.push_back(e);
  endtask

  // One clock cycle: drive inputs after the edge, then sample.
  task automatic step(input logic r, input logic pv, input logic [3:0] d,
                      input logic [3:0] l, input logic dv, input logic [61:0] dat,
                      input logic fr);
    @(posedge clk);
    #1;
    rst            = r;
    bus.pkt_valid  = pv;
    bus.pkt_dest   = d;
    bus.pkt_len    = l;
    bus.data_valid = dv;
    bus.data_in    = dat;
    bus.flit_ready = fr;
    #1;
    if (!r && bus.flit_valid && bus.flit_ready) cap.push_back(bus.flit_out);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b0, 62'd0, 1'b1);
  endtask

  // Hard stop in case something wedges the flow.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  localparam logic [61:0] A  = 62'h0AAA_0001, B  = 62'h0BBB_0002, C  = 62'h0CCC_0003;
  localparam logic [61:0] D  = 62'h0DDD_0004, E  = 62'h0EEE_0005;
  localparam logic [61:0] P1 = 62'h1111_0001, P2 = 62'h1111_0002;
  localparam logic [61:0] Q1 = 62'h2222_0001, Q2 = 62'h2222_0002;
  localparam logic [61:0] W1 = 62'h3333_0001, W2 = 62'h3333_0002, Z = 62'h3FFF_FFFF_FFFF_FFFF;

  initial begin
    logic [61:0] w [4];
    logic [63:0] exp6 [5];
    int          wi;
    logic        pkt_done;
    logic        dv;

    bus.pkt_valid = 1'b0; bus.pkt_dest = '0; bus.pkt_len = '0;
    bus.data_valid = 1'b0; bus.data_in = '0; bus.flit_ready = 1'b1;

    // ---- reset: readies held low, then clean idle state
    step(1'b1, 1'b1, 4'd5, 4'd3, 1'b1, A, 1'b1);
    step(1'b1, 1'b1, 4'd5, 4'd3, 1'b1, A, 1'b1);
    chk("rst pkt_ready", 64'(bus.pkt_ready), 64'd0);
    chk("rst data_ready", 64'(bus.data_ready), 64'd0);
    idle();
    chk("rst flit_valid", 64'(bus.flit_valid), 64'd0);
    chk("rst flit_out", bus.flit_out, 64'd0);
    chk("rst busy", 64'(bus.busy), 64'd0);

    // ---- 1: dest5 len3, A B C, ready=1
    add(1, 5, 3, 0, 0, 1,  0, 64'd0,     0, 1, 0);
    add(0, 0, 0, 1, A, 1,  1, hd(5, 3),  1, 0, 1);
    add(0, 0, 0, 1, B, 1,  1, pl(A),     1, 0, 1);
    add(0, 0, 0, 1, C, 1,  1, pl(B),     1, 0, 1);
    add(0, 0, 0, 0, 0, 1,  1, tl(C),     0, 1, 0);
    add(0, 0, 0, 0, 0, 1,  0, tl(C),     0, 1, 0);
    // ---- 2: same packet, downstream stalls three cycles on 2|B
    add(1, 5, 3, 0, 0, 1,  0, tl(C),     0, 1, 0);
    add(0, 0, 0, 1, A, 1,  1, hd(5, 3),  1, 0, 1);
    add(0, 0, 0, 1, B, 1,  1, pl(A),     1, 0, 1);
    add(0, 0, 0, 1, C, 0,  1, pl(B),     1, 0, 0);
    add(0, 0, 0, 1, C, 0,  1, pl(B),     1, 0, 0);
    add(0, 0, 0, 1, C, 0,  1, pl(B),     1, 0, 0);
    add(0, 0, 0, 1, C, 1,  1, pl(B),     1, 0, 1);
    add(0, 0, 0, 0, 0, 1,  1, tl(C),     0, 1, 0);
    add(0, 0, 0, 0, 0, 1,  0, tl(C),     0, 1, 0);
    // ---- 3: len=1 then len=0 (data offered but never taken)
    add(1, 2, 1, 0, 0, 1,  0, tl(C),     0, 1, 0);
    add(0, 0, 0, 1, D, 1,  1, hd(2, 1),  1, 0, 1);
    add(1, 7, 0, 0, 0, 1,  1, tl(D),     0, 1, 0);
    add(0, 0, 0, 1, E, 1,  1, hd(7, 0),  1, 0, 0);
    add(0, 0, 0, 1, E, 1,  1, tl(62'd0), 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,  0, tl(62'd0), 0, 1, 0);
    // ---- 4: two len=2 packets back to back; flit_valid unbroken for 6 cycles,
    //         state passes through IDLE for the single cycle the first tail drains
    add(1, 1, 2, 1, P1, 1, 0, tl(62'd0), 0, 1, 0);
    add(1, 3, 2, 1, P1, 1, 1, hd(1, 2),  1, 0, 1);
    add(1, 3, 2, 1, P2, 1, 1, pl(P1),    1, 0, 1);
    add(1, 3, 2, 1, Q1, 1, 1, tl(P2),    0, 1, 0);
    add(0, 0, 0, 1, Q1, 1, 1, hd(3, 2),  1, 0, 1);
    add(0, 0, 0, 1, Q2, 1, 1, pl(Q1),    1, 0, 1);
    add(0, 0, 0, 0, 0, 1,  1, tl(Q2),    0, 1, 0);
    add(0, 0, 0, 0, 0, 1,  0, tl(Q2),    0, 1, 0);

    foreach (vt[i]) begin
      step(1'b0, vt[i].pv, vt[i].dest, vt[i].len, vt[i].dv, vt[i].dat, vt[i].fr);
      chk($sformatf("vec%0d flit_valid", i), 64'(bus.flit_valid), 64'(vt[i].e_v));
      chk($sformatf("vec%0d flit_out", i),   bus.flit_out,        vt[i].e_out);
      chk($sformatf("vec%0d busy", i),       64'(bus.busy),       64'(vt[i].e_busy));
      chk($sformatf("vec%0d pkt_ready", i),  64'(bus.pkt_ready),  64'(vt[i].e_pr));
      chk($sformatf("vec%0d data_ready", i), 64'(bus.data_ready), 64'(vt[i].e_dr));
    end

    // ---- 5: reset after the 2nd flit of a len=4 packet, then a clean packet
    step(1'b0, 1'b1, 4'd9, 4'd4, 1'b0, 62'd0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, W1, 1'b1);
    chk("t5 head", bus.flit_out, hd(9, 4));
    step(1'b1, 1'b0, 4'd0, 4'd0, 1'b1, W2, 1'b1);
    chk("t5 second flit", bus.flit_out, pl(W1));
    chk("t5 rst pkt_ready", 64'(bus.pkt_ready), 64'd0);
    chk("t5 rst data_ready", 64'(bus.data_ready), 64'd0);
    idle();
    chk("t5 post-rst flit_valid", 64'(bus.flit_valid), 64'd0);
    chk("t5 post-rst busy", 64'(bus.busy), 64'd0);
    chk("t5 post-rst flit_out", bus.flit_out, 64'd0);
    chk("t5 post-rst pkt_ready", 64'(bus.pkt_ready), 64'd1);
    step(1'b0, 1'b1, 4'd4, 4'd1, 1'b0, 62'd0, 1'b1);
    step(1'b0, 1'b0, 4'd0, 4'd0, 1'b1, Z, 1'b1);
    chk("t5 clean head", bus.flit_out, hd(4, 1));
    chk("t5 clean data_ready", 64'(bus.data_ready), 64'd1);
    idle();
    chk("t5 clean tail", bus.flit_out, tl(Z));
    chk("t5 clean busy", 64'(bus.busy), 64'd0);
    idle();
    chk("t5 drained", 64'(bus.flit_valid), 64'd0);

    // ---- 6: data_valid toggling during a len=4 packet
    w[0] = 62'h0600_0001; w[1] = 62'h0600_0002; w[2] = 62'h0600_0003; w[3] = 62'h0600_0004;
    exp6[0] = hd(6, 4); exp6[1] = pl(w[0]); exp6[2] = pl(w[1]);
    exp6[3] = pl(w[2]); exp6[4] = tl(w[3]);
    cap.delete();
    wi = 0;
    pkt_done = 1'b0;
    for (int c = 0; c < 60 && cap.size() < 5; c++) begin
      dv = (c % 2 == 1) && (wi < 4);
      step(1'b0, !pkt_done, 4'd6, 4'd4, dv, w[(wi < 4) ? wi : 3], 1'b1);
      if (!pkt_done && bus.pkt_ready) pkt_done = 1'b1;
      if (dv && bus.data_ready) wi++;
    end
    for (int k = 0; k < 4; k++) idle();
    chk("t6 flit count", 64'(cap.size()), 64'd5);
    chk("t6 words consumed", 64'(wi), 64'd4);
    for (int k = 0; k < 5; k++) begin
      if (k < cap.size()) begin
        chk($sformatf("t6 flit%0d", k), cap[k], exp6[k]);
        chk($sformatf("t6 flit%0d type nonzero", k), 64'(cap[k][63:62] == 2'd0), 64'd0);
      end
    end
    chk("t6 final idle", 64'(bus.busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
